// File: rtl/jtframe_scan2x.sv
`default_nettype none
// ============================================================================
//  Module   : jtframe_scan2x
//  Purpose  : Single-clock line doubler. Converts 15 kHz video written on
//             pxl_cen into 31 kHz video read on pxl2_cen through a two-bank
//             line buffer, with optional horizontal blend and scanline dimming.
//  Revision : 1.0 - initial release
// ============================================================================
module jtframe_scan2x #(
    parameter int COLORW = 4,
    parameter int HLEN   = 512,
    parameter int HSW    = 32,
    parameter int BLEND  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pxl_cen,
    input  logic                  pxl2_cen,
    input  logic [3*COLORW-1:0]   base_pxl,
    input  logic                  HS,
    input  logic [1:0]            sl_mode,
    input  logic                  blend_en,
    output logic [3*COLORW-1:0]   x2_pxl,
    output logic                  x2_HS
);

    localparam int              c_AW       = $clog2(HLEN);
    localparam int              c_PW       = 3 * COLORW;
    localparam logic [c_AW-1:0] c_ADDR_MAX = c_AW'(HLEN - 1);
    localparam logic [c_AW-1:0] c_ONE      = c_AW'(1);
    localparam logic [31:0]     c_HSW      = 32'(HSW);

    // Line buffer: the top address bit selects the bank.
    logic [c_PW-1:0] r_mem [0:2*HLEN-1];

    logic [c_AW-1:0] r_wraddr;
    logic [c_AW-1:0] r_rdaddr;
    logic [c_AW-1:0] r_linelen;
    logic            r_wr_bank;
    logic            r_half;
    logic            r_hs_last;
    logic            w_hs_edge;
    logic [c_AW-1:0] w_rd_last;

    // Read pipeline stage registers
    logic [c_PW-1:0] r_rd_data;
    logic            r_s1_first;
    logic            r_s1_half;
    logic [c_AW-1:0] r_s1_cnt;
    logic [c_PW-1:0] w_blended;
    logic [c_PW-1:0] r_s2_pxl;
    logic            r_s2_half;
    logic [c_AW-1:0] r_s2_cnt;
    logic [c_PW-1:0] w_dimmed;

    // Truncating scanline attenuation of one channel.
    function automatic logic [COLORW-1:0] f_dim(input logic [COLORW-1:0] c,
                                                input logic [1:0]        mode);
        logic [COLORW-1:0] res;
        case (mode)
            2'd1:    res = c - (c >> 2);
            2'd2:    res = c >> 1;
            2'd3:    res = c >> 2;
            default: res = c;
        endcase
        return res;
    endfunction

    assign w_hs_edge = pxl_cen & HS & ~r_hs_last;
    assign w_rd_last = r_linelen - c_ONE;

    // Buffer write port; the read port never touches the bank being written.
    always_ff @(posedge clk) begin
        if (pxl_cen)
            r_mem[{r_wr_bank, r_wraddr}] <= base_pxl;
    end

    // Write address, bank swap and line length capture at each HS rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wraddr  <= '0;
            r_wr_bank <= 1'b0;
            r_linelen <= c_ADDR_MAX;
            r_hs_last <= 1'b0;
        end else if (pxl_cen) begin
            r_hs_last <= HS;
            if (w_hs_edge) begin
                // A zero length would make the read side wrap point undefined.
                r_linelen <= (r_wraddr == '0) ? c_ONE : r_wraddr;
                r_wraddr  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else if (r_wraddr != c_ADDR_MAX) begin
                r_wraddr  <= r_wraddr + c_ONE;
            end
        end
    end

    // Read address and half-line tracking; the input HS edge resyncs both.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdaddr <= '0;
            r_half   <= 1'b0;
        end else if (w_hs_edge) begin
            r_rdaddr <= '0;
            r_half   <= 1'b0;
        end else if (pxl2_cen) begin
            if (r_rdaddr == w_rd_last) begin
                r_rdaddr <= '0;
                r_half   <= ~r_half;
            end else begin
                r_rdaddr <= r_rdaddr + c_ONE;
            end
        end
    end

    // Stage 1: registered buffer read plus the control carried alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_s1_first <= 1'b0;
            r_s1_half  <= 1'b0;
            r_s1_cnt   <= '0;
        end else if (pxl2_cen) begin
            r_rd_data  <= r_mem[{~r_wr_bank, r_rdaddr}];
            r_s1_first <= (r_rdaddr == '0);
            r_s1_half  <= r_half;
            r_s1_cnt   <= r_rdaddr;
        end
    end

    generate
        if (BLEND != 0) begin : g_blend
            logic [c_PW-1:0] r_prev;
            logic [c_PW-1:0] w_prev_sel;
            logic [c_PW-1:0] w_avg;

            // Previous pixel of the line; not blended across line starts.
            always_ff @(posedge clk) begin
                if (rst)
                    r_prev <= '0;
                else if (pxl2_cen)
                    r_prev <= r_rd_data;
            end

            assign w_prev_sel = r_s1_first ? r_rd_data : r_prev;

            for (genvar i = 0; i < 3; i++) begin : g_ch
                logic [COLORW-1:0] w_a;
                logic [COLORW-1:0] w_b;
                assign w_a = r_rd_data[i*COLORW +: COLORW];
                assign w_b = w_prev_sel[i*COLORW +: COLORW];
                // floor((a+b)/2) without needing the extra sum bit
                assign w_avg[i*COLORW +: COLORW] = (w_a >> 1) + (w_b >> 1)
                    + {{(COLORW-1){1'b0}}, w_a[0] & w_b[0]};
            end

            assign w_blended = blend_en ? w_avg : r_rd_data;
        end else begin : g_no_blend
            assign w_blended = r_rd_data;
        end
    endgenerate

    // Stage 2: register the (optionally blended) pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_pxl  <= '0;
            r_s2_half <= 1'b0;
            r_s2_cnt  <= '0;
        end else if (pxl2_cen) begin
            r_s2_pxl  <= w_blended;
            r_s2_half <= r_s1_half;
            r_s2_cnt  <= r_s1_cnt;
        end
    end

    generate
        for (genvar i = 0; i < 3; i++) begin : g_sl
            assign w_dimmed[i*COLORW +: COLORW] = f_dim(r_s2_pxl[i*COLORW +: COLORW], sl_mode);
        end
    endgenerate

    // Stage 3: scanline dimming on the second output line and sync generation.
    always_ff @(posedge clk) begin
        if (rst) begin
            x2_pxl <= '0;
            x2_HS  <= 1'b0;
        end else if (pxl2_cen) begin
            x2_pxl <= r_s2_half ? w_dimmed : r_s2_pxl;
            x2_HS  <= (32'(r_s2_cnt) < c_HSW);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_scan2x.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtframe_scan2x
//  Purpose  : Self-checking bench for jtframe_scan2x against a behavioural
//             line-doubler model (buffer array, counters, output queue).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jtframe_scan2x;

    localparam int COLORW = 4;
    localparam int HLEN   = 512;
    localparam int HSW    = 32;
    localparam int LINE   = 384;

    logic        clk = 1'b0;
    logic        rst;
    logic        pxl_cen;
    logic        pxl2_cen;
    logic [11:0] base_pxl;
    logic        HS;
    logic [1:0]  sl_mode;
    logic        blend_en;
    logic [11:0] x2_pxl;
    logic        x2_HS;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int div    = 1;

    jtframe_scan2x #(.COLORW(COLORW), .HLEN(HLEN), .HSW(HSW), .BLEND(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .pxl_cen  (pxl_cen),
        .pxl2_cen (pxl2_cen),
        .base_pxl (base_pxl),
        .HS       (HS),
        .sl_mode  (sl_mode),
        .blend_en (blend_en),
        .x2_pxl   (x2_pxl),
        .x2_HS    (x2_HS)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [11:0] pxl;
        logic        pv;
        logic        hs;
        logic        hv;
    } exp_t;

    exp_t        q[$];
    logic [11:0] m_buf [0:2*HLEN-1];
    bit          m_wr  [0:2*HLEN-1];
    int          m_wraddr, m_rdaddr, m_linelen, m_bank, m_half;
    bit          m_hs_last, m_prev_v, m_bl;
    logic [1:0]  m_sl;
    logic [11:0] m_prev;
    logic [11:0] exp_pxl;
    bit          exp_pv, exp_hs, exp_hv;

    function automatic logic [11:0] f_avg(input logic [11:0] a, input logic [11:0] b);
        logic [11:0] r;
        for (int ch = 0; ch < 3; ch++)
            r[ch*4 +: 4] = 4'((int'(a[ch*4 +: 4]) + int'(b[ch*4 +: 4])) / 2);
        return r;
    endfunction

    function automatic logic [11:0] f_dim(input logic [11:0] a, input logic [1:0] m);
        logic [11:0] r;
        int c;
        for (int ch = 0; ch < 3; ch++) begin
            c = int'(a[ch*4 +: 4]);
            case (m)
                2'd1:    c = c - c / 4;
                2'd2:    c = c / 2;
                2'd3:    c = c / 4;
                default: c = c;
            endcase
            r[ch*4 +: 4] = 4'(c);
        end
        return r;
    endfunction

    // Advance the model by one clk using the inputs the DUT is about to sample.
    task automatic model();
        exp_t        e;
        logic [11:0] cur, pp, val;
        bit          cv, pv, edge_det;
        int          a;
        if (rst) begin
            m_wraddr = 0; m_rdaddr = 0; m_linelen = HLEN - 1;
            m_bank = 0; m_half = 0; m_hs_last = 0; m_prev_v = 0; m_prev = '0;
            foreach (m_wr[i]) m_wr[i] = 0;
            q.delete();
            e = '0;
            q.push_back(e);
            q.push_back(e);
            exp_pxl = '0; exp_pv = 1; exp_hs = 0; exp_hv = 1;
            m_sl = sl_mode; m_bl = blend_en;
            return;
        end
        edge_det = pxl_cen && HS && !m_hs_last;
        if (pxl2_cen) begin
            if (sl_mode !== m_sl || blend_en !== m_bl)
                foreach (q[i]) q[i].pv = 1'b0;
            m_sl = sl_mode; m_bl = blend_en;
            a   = (1 - m_bank) * HLEN + m_rdaddr;
            cur = m_buf[a];
            cv  = m_wr[a];
            if (m_rdaddr == 0) begin pp = cur; pv = cv; end
            else               begin pp = m_prev; pv = m_prev_v; end
            val = blend_en ? f_avg(cur, pp) : cur;
            if (m_half != 0) val = f_dim(val, sl_mode);
            e.pxl = val;
            e.pv  = cv && (pv || !blend_en);
            e.hs  = (m_rdaddr < HSW);
            e.hv  = 1'b1;
            q.push_back(e);
            m_prev = cur; m_prev_v = cv;
            e = q.pop_front();
            exp_pxl = e.pxl; exp_pv = e.pv; exp_hs = e.hs; exp_hv = e.hv;
            if (m_rdaddr == m_linelen - 1) begin
                m_rdaddr = 0;
                m_half   = 1 - m_half;
            end else begin
                m_rdaddr = (m_rdaddr + 1) % HLEN;
            end
        end
        if (pxl_cen) begin
            a = m_bank * HLEN + m_wraddr;
            m_buf[a] = base_pxl;
            m_wr[a]  = 1;
            if (edge_det) begin
                m_linelen = (m_wraddr == 0) ? 1 : m_wraddr;
                m_wraddr  = 0;
                m_bank    = 1 - m_bank;
                m_rdaddr  = 0;
                m_half    = 0;
            end else if (m_wraddr < HLEN - 1) begin
                m_wraddr++;
            end
            m_hs_last = HS;
        end
    endtask

    // One clk: drive inputs, step model, let the DUT clock, settle.
    task automatic step(input logic [11:0] pix, input logic hs_in, input logic rst_in);
        rst      = rst_in;
        pxl2_cen = (cyc % div) == 0;
        pxl_cen  = (cyc % (2 * div)) == 0;
        base_pxl = pix;
        HS       = hs_in;
        model();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        div = 1; cyc = 0;
        for (int c = 0; c < 8; c++) begin
            step(12'($urandom), 1'b0, 1'b1);
            checks++;
            if (x2_pxl !== 12'h000) begin
                errors++; $display("FAIL reset_pxl x2_pxl=%h expected=000", x2_pxl);
            end
            checks++;
            if (x2_HS !== 1'b0) begin
                errors++; $display("FAIL reset_hs x2_HS=%b expected=0", x2_HS);
            end
        end
    endtask

    task automatic test_ramp();
        int p, ln, per;
        div = 2; cyc = 0; sl_mode = 2'd0; blend_en = 1'b0;
        per = 2 * div;
        for (int c = 0; c < 4 * LINE * per; c++) begin
            p  = (c / per) % LINE;
            ln = c / (per * LINE);
            step(12'((ln * 53 + p * 7) & 12'hFFF), p < 8, 1'b0);
            if (exp_pv) begin
                checks++;
                if (x2_pxl !== exp_pxl) begin
                    errors++; $display("FAIL ramp_pxl t=%0t x2_pxl=%h expected=%h", $time, x2_pxl, exp_pxl);
                end
            end
            if (exp_hv) begin
                checks++;
                if (x2_HS !== exp_hs) begin
                    errors++; $display("FAIL ramp_hs t=%0t x2_HS=%b expected=%b", $time, x2_HS, exp_hs);
                end
            end
        end
    endtask

    task automatic test_scanline();
        int p;
        div = 1; cyc = 0; blend_en = 1'b0;
        for (int m = 1; m <= 3; m++) begin
            sl_mode = 2'(m);
            for (int c = 0; c < 3 * LINE * 2; c++) begin
                p = (c / 2) % LINE;
                step(12'hFFF, p < 8, 1'b0);
                if (exp_pv) begin
                    checks++;
                    if (x2_pxl !== exp_pxl) begin
                        errors++; $display("FAIL scan_pxl mode=%0d x2_pxl=%h expected=%h", m, x2_pxl, exp_pxl);
                    end
                end
                if (exp_hv) begin
                    checks++;
                    if (x2_HS !== exp_hs) begin
                        errors++; $display("FAIL scan_hs mode=%0d x2_HS=%b expected=%b", m, x2_HS, exp_hs);
                    end
                end
            end
        end
    endtask

    task automatic test_blend();
        int p;
        div = 1; cyc = 0; sl_mode = 2'd0; blend_en = 1'b1;
        for (int c = 0; c < 3 * LINE * 2; c++) begin
            p = (c / 2) % LINE;
            step(p[0] ? 12'hFFF : 12'h000, p < 8, 1'b0);
            if (exp_pv) begin
                checks++;
                if (x2_pxl !== exp_pxl) begin
                    errors++; $display("FAIL blend_pxl t=%0t x2_pxl=%h expected=%h", $time, x2_pxl, exp_pxl);
                end
            end
            if (exp_hv) begin
                checks++;
                if (x2_HS !== exp_hs) begin
                    errors++; $display("FAIL blend_hs t=%0t x2_HS=%b expected=%b", $time, x2_HS, exp_hs);
                end
            end
        end
        blend_en = 1'b0;
    endtask

    task automatic test_long_line();
        int lens [4] = '{700, LINE, LINE, LINE};
        div = 1; cyc = 0; sl_mode = 2'd0; blend_en = 1'b0;
        for (int ln = 0; ln < 4; ln++) begin
            for (int c = 0; c < 2 * lens[ln]; c++) begin
                step(12'($urandom), (c / 2) < 8, 1'b0);
                if (ln == 1 && c == 0) begin
                    checks++;
                    if (dut.r_linelen !== 9'd511) begin
                        errors++; $display("FAIL long_linelen linelen=%0d expected=511", dut.r_linelen);
                    end
                end
                if (exp_pv) begin
                    checks++;
                    if (x2_pxl !== exp_pxl) begin
                        errors++; $display("FAIL long_pxl line=%0d x2_pxl=%h expected=%h", ln, x2_pxl, exp_pxl);
                    end
                end
                if (exp_hv) begin
                    checks++;
                    if (x2_HS !== exp_hs) begin
                        errors++; $display("FAIL long_hs line=%0d x2_HS=%b expected=%b", ln, x2_HS, exp_hs);
                    end
                end
            end
        end
    endtask

    task automatic test_short_line();
        int lens [5] = '{LINE, 2, LINE, LINE, LINE};
        int hlen;
        div = 1; cyc = 0; sl_mode = 2'd2; blend_en = 1'b1;
        for (int ln = 0; ln < 5; ln++) begin
            hlen = (lens[ln] > 8) ? 8 : 1;
            for (int c = 0; c < 2 * lens[ln]; c++) begin
                step(12'($urandom), (c / 2) < hlen, 1'b0);
                if (ln == 2 && c == 0) begin
                    checks++;
                    if (dut.r_linelen !== 9'd1) begin
                        errors++; $display("FAIL short_linelen linelen=%0d expected=1", dut.r_linelen);
                    end
                end
                if (exp_pv) begin
                    checks++;
                    if (x2_pxl !== exp_pxl) begin
                        errors++; $display("FAIL short_pxl line=%0d x2_pxl=%h expected=%h", ln, x2_pxl, exp_pxl);
                    end
                end
                if (exp_hv) begin
                    checks++;
                    if (x2_HS !== exp_hs) begin
                        errors++; $display("FAIL short_hs line=%0d x2_HS=%b expected=%b", ln, x2_HS, exp_hs);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        int p, mid;
        div = 1; cyc = 0;
        for (int ln = 0; ln < 6; ln++) begin
            mid = $urandom_range(20, LINE - 20);
            for (int c = 0; c < 2 * LINE; c++) begin
                p = c / 2;
                if (c == 0) begin
                    sl_mode  = 2'($urandom);
                    blend_en = 1'($urandom);
                end else if (c == 2 * mid) begin
                    sl_mode  = 2'($urandom);
                end
                step(12'($urandom), p < 8, 1'b0);
                if (exp_pv) begin
                    checks++;
                    if (x2_pxl !== exp_pxl) begin
                        errors++; $display("FAIL rand_pxl line=%0d x2_pxl=%h expected=%h", ln, x2_pxl, exp_pxl);
                    end
                end
                if (exp_hv) begin
                    checks++;
                    if (x2_HS !== exp_hs) begin
                        errors++; $display("FAIL rand_hs line=%0d x2_HS=%b expected=%b", ln, x2_HS, exp_hs);
                    end
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int p;
        div = 1; cyc = 0; sl_mode = 2'd1; blend_en = 1'b0;
        for (int c = 0; c < 5 * LINE * 2; c++) begin
            p = (c / 2) % LINE;
            step(12'($urandom), p < 8, c == 2 * (LINE + 200));
            if (c == 2 * (LINE + 200)) begin
                checks++;
                if (x2_pxl !== 12'h000 || x2_HS !== 1'b0) begin
                    errors++; $display("FAIL midrst_out x2_pxl=%h x2_HS=%b expected=000/0", x2_pxl, x2_HS);
                end
                checks++;
                if (dut.r_wraddr !== '0 || dut.r_rdaddr !== '0 || dut.r_wr_bank !== 1'b0 || dut.r_half !== 1'b0) begin
                    errors++; $display("FAIL midrst_cnt wraddr=%0d rdaddr=%0d bank=%b half=%b expected=0",
                                       dut.r_wraddr, dut.r_rdaddr, dut.r_wr_bank, dut.r_half);
                end
            end
            if (exp_pv) begin
                checks++;
                if (x2_pxl !== exp_pxl) begin
                    errors++; $display("FAIL midrst_pxl t=%0t x2_pxl=%h expected=%h", $time, x2_pxl, exp_pxl);
                end
            end
            if (exp_hv) begin
                checks++;
                if (x2_HS !== exp_hs) begin
                    errors++; $display("FAIL midrst_hs t=%0t x2_HS=%b expected=%b", $time, x2_HS, exp_hs);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; pxl_cen = 1'b0; pxl2_cen = 1'b0; base_pxl = '0;
        HS = 1'b0; sl_mode = 2'd0; blend_en = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_ramp();
        test_scanline();
        test_blend();
        test_long_line();
        test_short_line();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
